// File: rtl/rename_regfile_pkg.sv
// Shared sizing and types for the rename register file: rename entries and the dispatch packet.
package rename_regfile_pkg;

  localparam int unsigned GprCount   = 32;
  localparam int unsigned GprSize    = 64;
  localparam int unsigned RobIdxSize = 4;
  localparam int unsigned ImmSize    = 16;
  localparam int unsigned NumCommit  = 2;
  localparam int unsigned GprIdx     = $clog2(GprCount);

  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic                  valid;
    logic [RobIdxSize-1:0] tag;
    logic [GprSize-1:0]    value;
  } gpr_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [RobIdxSize-1:0] tag;
    nzcv_t                 value;
  } nzcv_entry_t;

  typedef struct packed {
    gpr_entry_t            src1;
    gpr_entry_t            src2;
    nzcv_entry_t           nzcv;
    logic [GprIdx-1:0]     dst;
    logic                  dst_we;
    logic                  set_nzcv;
    logic [RobIdxSize-1:0] rob_index;
  } dispatch_pkt_t;

  // An operand that needs no producer: valid, tag cleared.
  function automatic gpr_entry_t entry_resolved(input logic [GprSize-1:0] v);
    return '{valid: 1'b1, tag: '0, value: v};
  endfunction

endpackage

// File: rtl/rename_bypass.sv
// Per-operand commit bypass: a same-cycle commit whose tag matches the entry's current rename
// tag supplies the operand directly; the highest-index matching port wins.
module rename_bypass #(
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 4,
  parameter int unsigned NumPorts = 2
) (
  input  logic                         entry_valid_i,
  input  logic [TagWidth-1:0]          entry_tag_i,
  input  logic [Width-1:0]             entry_value_i,
  input  logic [NumPorts-1:0]          port_hit_i,
  input  logic [NumPorts*TagWidth-1:0] port_tag_i,
  input  logic [NumPorts*Width-1:0]    port_value_i,
  output logic                         valid_o,
  output logic [TagWidth-1:0]          tag_o,
  output logic [Width-1:0]             value_o
);

  always_comb begin
    valid_o = entry_valid_i;
    tag_o   = entry_tag_i;
    value_o = entry_value_i;
    for (int k = 0; k < NumPorts; k++) begin
      if (port_hit_i[k] && (port_tag_i[k*TagWidth +: TagWidth] == entry_tag_i)) begin
        valid_o = 1'b1;
        value_o = port_value_i[k*Width +: Width];
      end
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural GPR/NZCV state with ROB-tag renaming, multi-port commit, bypass and flush.
// Define ZERO_REG_EN to make index GPR_COUNT-1 a hardwired zero register.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int unsigned GPR_COUNT    = GprCount,
  parameter int unsigned GPR_SIZE     = GprSize,
  parameter int unsigned ROB_IDX_SIZE = RobIdxSize,
  parameter int unsigned IMM_SIZE     = ImmSize,
  parameter int unsigned NUM_COMMIT   = NumCommit,
  parameter int unsigned GIDX         = $clog2(GPR_COUNT)
) (
  input  logic                               in_clk,
  input  logic                               in_rst,
  input  logic                               in_d_done,
  output logic                               out_d_ready,
  input  logic [GIDX-1:0]                    in_d_src1,
  input  logic [GIDX-1:0]                    in_d_src2,
  input  logic [GIDX-1:0]                    in_d_dst,
  input  logic                               in_d_dst_we,
  input  logic                               in_d_set_nzcv,
  input  logic                               in_d_use_imm,
  input  logic [IMM_SIZE-1:0]                in_d_imm,
  input  logic [ROB_IDX_SIZE-1:0]            in_d_rob_index,
  input  logic                               in_rob_ready,
  input  logic                               in_rob_flush,
  input  logic [NUM_COMMIT-1:0]              in_rob_commit_valid,
  input  logic [NUM_COMMIT-1:0]              in_rob_commit_we,
  input  logic [NUM_COMMIT*GIDX-1:0]         in_rob_commit_reg,
  input  logic [NUM_COMMIT*GPR_SIZE-1:0]     in_rob_commit_value,
  input  logic [NUM_COMMIT*ROB_IDX_SIZE-1:0] in_rob_commit_tag,
  input  logic [NUM_COMMIT-1:0]              in_rob_commit_set_nzcv,
  input  logic [NUM_COMMIT*4-1:0]            in_rob_commit_nzcv,
  output logic                               out_rob_done,
  output logic                               out_rob_src1_valid,
  output logic [GPR_SIZE-1:0]                out_rob_src1_value,
  output logic [ROB_IDX_SIZE-1:0]            out_rob_src1_tag,
  output logic                               out_rob_src2_valid,
  output logic [GPR_SIZE-1:0]                out_rob_src2_value,
  output logic [ROB_IDX_SIZE-1:0]            out_rob_src2_tag,
  output logic                               out_rob_nzcv_valid,
  output logic [3:0]                         out_rob_nzcv,
  output logic [ROB_IDX_SIZE-1:0]            out_rob_nzcv_tag,
  output logic [GIDX-1:0]                    out_rob_dst,
  output logic                               out_rob_dst_we,
  output logic                               out_rob_set_nzcv,
  output logic [ROB_IDX_SIZE-1:0]            out_rob_rob_index
);

`ifdef ZERO_REG_EN
  localparam logic [GIDX-1:0] ZeroIdx = GIDX'(GPR_COUNT - 1);
`endif

  gpr_entry_t    gpr_q [GPR_COUNT];
  gpr_entry_t    gpr_d [GPR_COUNT];
  nzcv_entry_t   nzcv_q, nzcv_d;
  dispatch_pkt_t pkt_q, pkt_d;
  logic          done_q, done_d;
  logic          accept;
  logic          dst_we_eff;

  logic [GIDX-1:0]         c_reg   [NUM_COMMIT];
  logic [GPR_SIZE-1:0]     c_value [NUM_COMMIT];
  logic [ROB_IDX_SIZE-1:0] c_tag   [NUM_COMMIT];
  nzcv_t                   c_nzcv  [NUM_COMMIT];
  logic [NUM_COMMIT-1:0]   c_gpr_we, c_flag_we, src1_hit, src2_hit;

  logic                    src1_valid, src2_valid, flag_valid;
  logic [GPR_SIZE-1:0]     src1_value, src2_value;
  logic [ROB_IDX_SIZE-1:0] src1_tag, src2_tag, flag_tag;
  nzcv_t                   flag_value;

  // A flush cycle never accepts, so flush and rename are mutually exclusive below.
  assign out_d_ready = ~in_rst & ~in_rob_flush & (~done_q | in_rob_ready);
  assign accept      = in_d_done & out_d_ready;

`ifdef ZERO_REG_EN
  assign dst_we_eff = in_d_dst_we & (in_d_dst != ZeroIdx);
`else
  assign dst_we_eff = in_d_dst_we;
`endif

  always_comb begin
    for (int k = 0; k < NUM_COMMIT; k++) begin
      c_reg[k]     = in_rob_commit_reg[k*GIDX +: GIDX];
      c_value[k]   = in_rob_commit_value[k*GPR_SIZE +: GPR_SIZE];
      c_tag[k]     = in_rob_commit_tag[k*ROB_IDX_SIZE +: ROB_IDX_SIZE];
      c_nzcv[k]    = in_rob_commit_nzcv[k*4 +: 4];
      c_gpr_we[k]  = in_rob_commit_valid[k] & in_rob_commit_we[k];
`ifdef ZERO_REG_EN
      if (c_reg[k] == ZeroIdx) c_gpr_we[k] = 1'b0;
`endif
      c_flag_we[k] = in_rob_commit_valid[k] & in_rob_commit_set_nzcv[k];
      src1_hit[k]  = c_gpr_we[k] & (c_reg[k] == in_d_src1);
      src2_hit[k]  = c_gpr_we[k] & (c_reg[k] == in_d_src2);
    end
  end

  rename_bypass #(
    .Width    (GPR_SIZE),
    .TagWidth (ROB_IDX_SIZE),
    .NumPorts (NUM_COMMIT)
  ) u_bypass_src1 (
    .entry_valid_i (gpr_q[in_d_src1].valid),
    .entry_tag_i   (gpr_q[in_d_src1].tag),
    .entry_value_i (gpr_q[in_d_src1].value),
    .port_hit_i    (src1_hit),
    .port_tag_i    (in_rob_commit_tag),
    .port_value_i  (in_rob_commit_value),
    .valid_o       (src1_valid),
    .tag_o         (src1_tag),
    .value_o       (src1_value)
  );

  rename_bypass #(
    .Width    (GPR_SIZE),
    .TagWidth (ROB_IDX_SIZE),
    .NumPorts (NUM_COMMIT)
  ) u_bypass_src2 (
    .entry_valid_i (gpr_q[in_d_src2].valid),
    .entry_tag_i   (gpr_q[in_d_src2].tag),
    .entry_value_i (gpr_q[in_d_src2].value),
    .port_hit_i    (src2_hit),
    .port_tag_i    (in_rob_commit_tag),
    .port_value_i  (in_rob_commit_value),
    .valid_o       (src2_valid),
    .tag_o         (src2_tag),
    .value_o       (src2_value)
  );

  rename_bypass #(
    .Width    (4),
    .TagWidth (ROB_IDX_SIZE),
    .NumPorts (NUM_COMMIT)
  ) u_bypass_nzcv (
    .entry_valid_i (nzcv_q.valid),
    .entry_tag_i   (nzcv_q.tag),
    .entry_value_i (nzcv_q.value),
    .port_hit_i    (c_flag_we),
    .port_tag_i    (in_rob_commit_tag),
    .port_value_i  (in_rob_commit_nzcv),
    .valid_o       (flag_valid),
    .tag_o         (flag_tag),
    .value_o       (flag_value)
  );

  // Commits first, then flush or rename, so a same-cycle rename leaves the entry pending.
  always_comb begin
    gpr_d  = gpr_q;
    nzcv_d = nzcv_q;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      if (c_gpr_we[k]) begin
        gpr_d[c_reg[k]].value = c_value[k];
        if (c_tag[k] == gpr_q[c_reg[k]].tag) gpr_d[c_reg[k]].valid = 1'b1;
      end
      if (c_flag_we[k]) begin
        nzcv_d.value = c_nzcv[k];
        if (c_tag[k] == nzcv_q.tag) nzcv_d.valid = 1'b1;
      end
    end
    if (in_rob_flush) begin
      for (int i = 0; i < GPR_COUNT; i++) gpr_d[i].valid = 1'b1;
      nzcv_d.valid = 1'b1;
    end else if (accept) begin
      if (dst_we_eff) begin
        gpr_d[in_d_dst].valid = 1'b0;
        gpr_d[in_d_dst].tag   = in_d_rob_index;
      end
      if (in_d_set_nzcv) begin
        nzcv_d.valid = 1'b0;
        nzcv_d.tag   = in_d_rob_index;
      end
    end
  end

  always_comb begin
    done_d = done_q;
    pkt_d  = pkt_q;
    if (in_rob_flush) begin
      done_d = 1'b0;
    end else if (accept) begin
      done_d         = 1'b1;
      pkt_d.src1     = '{valid: src1_valid, tag: src1_tag, value: src1_value};
      pkt_d.src2     = '{valid: src2_valid, tag: src2_tag, value: src2_value};
`ifdef ZERO_REG_EN
      if (in_d_src1 == ZeroIdx) pkt_d.src1 = entry_resolved('0);
      if (in_d_src2 == ZeroIdx) pkt_d.src2 = entry_resolved('0);
`endif
      if (in_d_use_imm) pkt_d.src2 = entry_resolved(GprSize'(in_d_imm));
      pkt_d.nzcv      = '{valid: flag_valid, tag: flag_tag, value: flag_value};
      pkt_d.dst       = in_d_dst;
      pkt_d.dst_we    = in_d_dst_we;
      pkt_d.set_nzcv  = in_d_set_nzcv;
      pkt_d.rob_index = in_d_rob_index;
    end else if (in_rob_ready) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < GPR_COUNT; i++) gpr_q[i] <= entry_resolved('0);
      nzcv_q <= '{valid: 1'b1, default: '0};
      done_q <= 1'b0;
      pkt_q  <= '0;
    end else begin
      gpr_q  <= gpr_d;
      nzcv_q <= nzcv_d;
      done_q <= done_d;
      pkt_q  <= pkt_d;
    end
  end

  assign out_rob_done       = done_q;
  assign out_rob_src1_valid = pkt_q.src1.valid;
  assign out_rob_src1_value = pkt_q.src1.value;
  assign out_rob_src1_tag   = pkt_q.src1.tag;
  assign out_rob_src2_valid = pkt_q.src2.valid;
  assign out_rob_src2_value = pkt_q.src2.value;
  assign out_rob_src2_tag   = pkt_q.src2.tag;
  assign out_rob_nzcv_valid = pkt_q.nzcv.valid;
  assign out_rob_nzcv       = pkt_q.nzcv.value;
  assign out_rob_nzcv_tag   = pkt_q.nzcv.tag;
  assign out_rob_dst        = pkt_q.dst;
  assign out_rob_dst_we     = pkt_q.dst_we;
  assign out_rob_set_nzcv   = pkt_q.set_nzcv;
  assign out_rob_rob_index  = pkt_q.rob_index;

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: array-based reference model plus directed scenarios.
module tb_rename_regfile;

  localparam int NC = 2;
`ifdef ZERO_REG_EN
  localparam bit ZeroEn = 1'b1;
`else
  localparam bit ZeroEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, d_done, d_dst_we, d_setf, d_use_imm, rob_ready, flush;
  logic [4:0]  d_src1, d_src2, d_dst;
  logic [15:0] d_imm;
  logic [3:0]  d_rob;
  logic [NC-1:0] c_valid, c_we, c_setf;
  logic [4:0]  c_reg  [NC];
  logic [63:0] c_val  [NC];
  logic [3:0]  c_tag  [NC];
  logic [3:0]  c_nzcv [NC];

  logic        d_ready, done, s1v, s2v, fv, o_dst_we, o_setf;
  logic [63:0] s1val, s2val;
  logic [3:0]  s1t, s2t, f, ft, o_rob;
  logic [4:0]  o_dst;

  rename_regfile dut (
    .in_clk                 (clk),
    .in_rst                 (rst),
    .in_d_done              (d_done),
    .out_d_ready            (d_ready),
    .in_d_src1              (d_src1),
    .in_d_src2              (d_src2),
    .in_d_dst               (d_dst),
    .in_d_dst_we            (d_dst_we),
    .in_d_set_nzcv          (d_setf),
    .in_d_use_imm           (d_use_imm),
    .in_d_imm               (d_imm),
    .in_d_rob_index         (d_rob),
    .in_rob_ready           (rob_ready),
    .in_rob_flush           (flush),
    .in_rob_commit_valid    (c_valid),
    .in_rob_commit_we       (c_we),
    .in_rob_commit_reg      ({c_reg[1], c_reg[0]}),
    .in_rob_commit_value    ({c_val[1], c_val[0]}),
    .in_rob_commit_tag      ({c_tag[1], c_tag[0]}),
    .in_rob_commit_set_nzcv (c_setf),
    .in_rob_commit_nzcv     ({c_nzcv[1], c_nzcv[0]}),
    .out_rob_done           (done),
    .out_rob_src1_valid     (s1v),
    .out_rob_src1_value     (s1val),
    .out_rob_src1_tag       (s1t),
    .out_rob_src2_valid     (s2v),
    .out_rob_src2_value     (s2val),
    .out_rob_src2_tag       (s2t),
    .out_rob_nzcv_valid     (fv),
    .out_rob_nzcv           (f),
    .out_rob_nzcv_tag       (ft),
    .out_rob_dst            (o_dst),
    .out_rob_dst_we         (o_dst_we),
    .out_rob_set_nzcv       (o_setf),
    .out_rob_rob_index      (o_rob)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state and the packet it predicts.
  bit          m_live = 1'b0;
  bit          m_v   [32];
  logic [3:0]  m_t   [32];
  logic [63:0] m_val [32];
  bit          m_fv;
  logic [3:0]  m_ft, m_f;
  bit          e_done = 1'b0;
  bit          e_s1v, e_s2v, e_fv, e_dstwe, e_setf, e_imm;
  logic [63:0] e_s1val, e_s2val;
  logic [3:0]  e_s1t, e_s2t, e_ft, e_f, e_rob;
  logic [4:0]  e_dst;

  function automatic bit is_zero(input logic [4:0] r);
    return ZeroEn && (r == 5'd31);
  endfunction

  task automatic gpr_read(input logic [4:0] r, output bit v, output logic [63:0] val,
                          output logic [3:0] t);
    v = m_v[r];
    val = m_val[r];
    t = m_t[r];
    for (int k = 0; k < NC; k++)
      if (c_valid[k] && c_we[k] && c_reg[k] == r && c_tag[k] == m_t[r]) begin
        v = 1'b1;
        val = c_val[k];
      end
    if (is_zero(r)) begin
      v = 1'b1;
      val = '0;
      t = '0;
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_v[i] = 1'b1;
        m_t[i] = '0;
        m_val[i] = '0;
      end
      m_fv = 1'b1; m_ft = '0; m_f = '0;
      e_done = 1'b0;
      m_live = 1'b1;
    end else begin
      acc = d_done && (!e_done || rob_ready) && !flush;
      if (acc) begin
        gpr_read(d_src1, e_s1v, e_s1val, e_s1t);
        e_imm = d_use_imm;
        if (d_use_imm) begin
          e_s2v = 1'b1; e_s2val = {48'b0, d_imm}; e_s2t = '0;
        end else begin
          gpr_read(d_src2, e_s2v, e_s2val, e_s2t);
        end
        e_fv = m_fv; e_f = m_f; e_ft = m_ft;
        for (int k = 0; k < NC; k++)
          if (c_valid[k] && c_setf[k] && c_tag[k] == m_ft) begin
            e_fv = 1'b1; e_f = c_nzcv[k];
          end
        e_dst = d_dst; e_dstwe = d_dst_we; e_setf = d_setf; e_rob = d_rob;
      end
      for (int k = 0; k < NC; k++) begin
        if (c_valid[k] && c_we[k] && !is_zero(c_reg[k])) begin
          if (c_tag[k] == m_t[c_reg[k]]) m_v[c_reg[k]] = 1'b1;
          m_val[c_reg[k]] = c_val[k];
        end
        if (c_valid[k] && c_setf[k]) begin
          if (c_tag[k] == m_ft) m_fv = 1'b1;
          m_f = c_nzcv[k];
        end
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_v[i] = 1'b1;
        m_fv = 1'b1;
      end
      if (acc && d_dst_we && !is_zero(d_dst)) begin
        m_v[d_dst] = 1'b0; m_t[d_dst] = d_rob;
      end
      if (acc && d_setf) begin
        m_fv = 1'b0; m_ft = d_rob;
      end
      if (flush) e_done = 1'b0;
      else if (acc) e_done = 1'b1;
      else if (rob_ready) e_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      chk("ready", d_ready, (!e_done || rob_ready) && !flush);
      chk("done", done, e_done);
      if (e_done) begin
        chk("src1_valid", s1v, e_s1v);
        if (e_s1v) chk("src1_value", s1val, e_s1val);
        else chk("src1_tag", s1t, e_s1t);
        chk("src2_valid", s2v, e_s2v);
        if (e_s2v) chk("src2_value", s2val, e_s2val);
        if (!e_s2v || e_imm) chk("src2_tag", s2t, e_s2t);
        chk("nzcv_valid", fv, e_fv);
        if (e_fv) chk("nzcv", f, e_f);
        else chk("nzcv_tag", ft, e_ft);
        chk("dst", o_dst, e_dst);
        chk("dst_we", o_dst_we, e_dstwe);
        chk("set_nzcv", o_setf, e_setf);
        chk("rob_index", o_rob, e_rob);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_done = 0; d_src1 = 0; d_src2 = 0; d_dst = 0; d_dst_we = 0; d_setf = 0;
    d_use_imm = 0; d_imm = 0; d_rob = 0; flush = 0;
    c_valid = 0; c_we = 0; c_setf = 0;
    for (int k = 0; k < NC; k++) begin
      c_reg[k] = 0; c_val[k] = 0; c_tag[k] = 0; c_nzcv[k] = 0;
    end
  endtask

  task automatic disp(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] dst,
                      input bit we, input bit setf, input logic [3:0] rob);
    d_done = 1; d_src1 = s1; d_src2 = s2; d_dst = dst; d_dst_we = we; d_setf = setf;
    d_rob = rob; d_use_imm = 0;
  endtask

  task automatic commit(input int p, input logic [4:0] r, input logic [63:0] v,
                        input logic [3:0] t);
    c_valid[p] = 1; c_we[p] = 1; c_reg[p] = r; c_val[p] = v; c_tag[p] = t;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; rob_ready = 1;
    idle();
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_src1_valid", s1v, 0);
    chk("rst_rob_index", o_rob, 0);
    chk("rst_ready", d_ready, 1);

    // Reset values read back as resolved zeros.
    disp(3, 4, 0, 0, 0, 4'd1); tick(); idle();
    chk("t1_done", done, 1);
    chk("t1_s1v", s1v, 1); chk("t1_s1val", s1val, 0);
    chk("t1_s2v", s2v, 1); chk("t1_s2val", s2val, 0);

    // Rename, pending read, commit, resolved read.
    disp(0, 0, 5, 1, 0, 4'd2); tick();
    disp(5, 0, 0, 0, 0, 4'd3); tick(); idle();
    chk("t2_pending_v", s1v, 0); chk("t2_pending_tag", s1t, 2);
    commit(0, 5, 64'hAB, 4'd2); tick(); idle();
    disp(5, 0, 0, 0, 0, 4'd4); tick(); idle();
    chk("t2_commit_v", s1v, 1); chk("t2_commit_val", s1val, 64'hAB);

    // Same-cycle commit bypass on port 1.
    disp(0, 0, 5, 1, 0, 4'd2); tick();
    disp(5, 0, 0, 0, 0, 4'd5); commit(1, 5, 64'd7, 4'd2); tick(); idle();
    chk("t3_bypass_v", s1v, 1); chk("t3_bypass_val", s1val, 7);

    // Stale commit writes the value but leaves the newer rename pending.
    disp(0, 0, 6, 1, 0, 4'd1); tick();
    disp(0, 0, 6, 1, 0, 4'd3); tick(); idle();
    commit(0, 6, 64'd9, 4'd1); tick(); idle();
    disp(6, 0, 0, 0, 0, 4'd6); tick(); idle();
    chk("t4_stale_v", s1v, 0); chk("t4_stale_tag", s1t, 3);

    // Two ports to one register: port 1 wins; immediate zero-extended on src2.
    commit(0, 7, 64'h11, 4'd0); commit(1, 7, 64'h22, 4'd0); tick(); idle();
    disp(7, 0, 0, 0, 0, 4'd7); d_use_imm = 1; d_imm = 16'hBEEF; tick(); idle();
    chk("dual_val", s1val, 64'h22);
    chk("imm_v", s2v, 1); chk("imm_val", s2val, 64'hBEEF); chk("imm_tag", s2t, 0);

    // Back-pressure holds the packet and blocks dispatch.
    disp(3, 0, 9, 0, 0, 4'd4); tick();
    disp(5, 0, 0, 0, 0, 4'd5); rob_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_ready_low", d_ready, 0);
      tick();
      chk("t5_hold_done", done, 1); chk("t5_hold_rob", o_rob, 4); chk("t5_hold_dst", o_dst, 9);
    end
    rob_ready = 1; #1;
    chk("t5_release_ready", d_ready, 1);
    tick(); idle();
    chk("t5_next_rob", o_rob, 5);

    // Flush restores committed values and flags, blocks dispatch, drops the pending packet.
    disp(0, 0, 2, 1, 1, 4'd6); tick(); idle();
    commit(0, 2, 64'h55, 4'd9);
    c_valid[1] = 1; c_setf[1] = 1; c_nzcv[1] = 4'hA; c_tag[1] = 4'd8;
    tick(); idle();
    disp(2, 0, 0, 0, 0, 4'd7); tick(); idle();
    chk("t6_pre_v", s1v, 0); chk("t6_pre_tag", s1t, 6);
    chk("t6_pre_fv", fv, 0); chk("t6_pre_ftag", ft, 6);
    rob_ready = 0; disp(2, 0, 0, 0, 0, 4'd8); flush = 1; #1;
    chk("t6_flush_ready", d_ready, 0);
    tick(); idle(); rob_ready = 1;
    chk("t6_flush_done", done, 0);
    disp(2, 6, 0, 0, 0, 4'd9); tick(); idle();
    chk("t6_s1v", s1v, 1); chk("t6_s1val", s1val, 64'h55);
    chk("t6_s2v", s2v, 1); chk("t6_s2val", s2val, 9);
    chk("t6_fv", fv, 1); chk("t6_nzcv", f, 4'hA);

    // Highest index: zero register when enabled, ordinary register otherwise.
    commit(0, 31, 64'd5, 4'd0); tick(); idle();
    disp(31, 0, 0, 0, 0, 4'd10); tick(); idle();
    chk("r31_v", s1v, 1); chk("r31_val", s1val, ZeroEn ? 64'd0 : 64'd5);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
